// File: rtl/hazard_ctrl_unit_if.sv
// rtl/hazard_ctrl_unit_if.sv - stage fields in, stall/flush/forward controls out
interface hazard_ctrl_unit_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic       RegWriteE;
  logic [2:0] ResultSrcE;
  logic       MemWriteE;
  logic       PCSrcE;
  logic       dmem_ready;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       StallE;
  logic       FlushE;
  logic       StallM;
  logic       FlushW;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       mem_timeout;

  // Hazard unit side: reads pipeline-register fields, drives the controls.
  modport master (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, MemWriteE, PCSrcE, dmem_ready,
    output StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW, ForwardAE, ForwardBE, mem_timeout
  );

  // Datapath side: presents stage fields, obeys the controls.
  modport slave (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE, MemWriteE, PCSrcE, dmem_ready,
    input  StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW, ForwardAE, ForwardBE, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - RV32 pipeline hazard control with dmem wait FSM
module hazard_ctrl_unit #(
  parameter logic [2:0] LOAD_SRC = 3'b001,
  parameter int         MAX_WAIT = 16,
  parameter int         CNT_W    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_ctrl_unit_if.master    hzBus
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  // Shadow of the M/W destination fields, kept here so forwarding does not
  // need the EX_MEM/MEM_WB registers routed back.
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             memM;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             memTimeout;

  logic isLoadE;
  logic memStall;
  logic lwStall;

  assign isLoadE  = (hzBus.ResultSrcE == LOAD_SRC);
  assign memStall = memM & ~hzBus.dmem_ready;
  assign lwStall  = isLoadE & hzBus.RegWriteE & (hzBus.RdE != 5'd0) &
                    ((hzBus.RdE == hzBus.Rs1D) | (hzBus.RdE == hzBus.Rs2D));

  function automatic logic [1:0] fwdSel(input logic [4:0] rs, input logic [4:0] rdM,
                                        input logic rwM, input logic [4:0] rdW, input logic rwW);
    logic [1:0] sel;
    sel = 2'b00;
    if (rwM && (rdM != 5'd0) && (rdM == rs))
      sel = 2'b10;
    else if (rwW && (rdW != 5'd0) && (rdW == rs))
      sel = 2'b01;
    return sel;
  endfunction

  // Stall/flush/forward decode; reset forces every control quiet immediately.
  always_comb begin
    hzBus.StallF    = 1'b0;
    hzBus.StallD    = 1'b0;
    hzBus.FlushD    = 1'b0;
    hzBus.StallE    = 1'b0;
    hzBus.FlushE    = 1'b0;
    hzBus.StallM    = 1'b0;
    hzBus.FlushW    = 1'b0;
    hzBus.ForwardAE = 2'b00;
    hzBus.ForwardBE = 2'b00;
    if (!reset) begin
      if (memStall) begin
        // Freeze everything up to M; a taken branch waits in EX until release.
        hzBus.StallF = 1'b1;
        hzBus.StallD = 1'b1;
        hzBus.StallE = 1'b1;
        hzBus.StallM = 1'b1;
        hzBus.FlushW = 1'b1;
      end else begin
        hzBus.StallF = lwStall;
        hzBus.StallD = lwStall;
        hzBus.FlushD = hzBus.PCSrcE;
        hzBus.FlushE = lwStall | hzBus.PCSrcE;
      end
      hzBus.ForwardAE = fwdSel(hzBus.Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      hzBus.ForwardBE = fwdSel(hzBus.Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end
  end

  assign hzBus.mem_timeout = memTimeout;

  // Shadow pipe: advance with the datapath, or hold M and bubble W during a dmem wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RdM       <= 5'd0;
      RdW       <= 5'd0;
      RegWriteM <= 1'b0;
      RegWriteW <= 1'b0;
      memM      <= 1'b0;
    end else if (memStall) begin
      RdW       <= 5'd0;
      RegWriteW <= 1'b0;
    end else begin
      RdM       <= hzBus.RdE;
      RegWriteM <= hzBus.RegWriteE;
      memM      <= isLoadE | hzBus.MemWriteE;
      RdW       <= RdM;
      RegWriteW <= RegWriteM;
    end
  end

  // Dmem wait FSM: counts consecutive wait cycles and latches a sticky timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      cnt        <= '0;
      memTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memStall) begin
            state <= MEM_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (memStall) begin
            if (cnt != CNT_W'(MAX_WAIT))
              cnt <= cnt + 1'b1;
            else
              memTimeout <= 1'b1;
          end else begin
            state <= RUN;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - scoreboard bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

  localparam logic [2:0] LOAD_SRC = 3'b001;
  localparam int         MAX_WAIT = 16;

  // Control bit order: {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LW   = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_BRLW = 7'b1110100;
  localparam logic [6:0] C_MEM  = 7'b1101011;

  typedef struct {
    string      tag;
    logic [6:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       tmo;
    logic       tmoCare;
  } exp_t;

  logic clk;
  logic reset;
  int   vecCount;
  int   errCount;
  exp_t sbQ[$];

  hazard_ctrl_unit_if hzBus();

  hazard_ctrl_unit #(
    .LOAD_SRC(LOAD_SRC),
    .MAX_WAIT(MAX_WAIT),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hzBus(hzBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus: applied just after the rising edge, expectation queued.
  task automatic drive(input string tag, input bit rst,
                       input logic [4:0] rs1d, input logic [4:0] rs2d,
                       input logic [4:0] rs1e, input logic [4:0] rs2e, input logic [4:0] rde,
                       input bit regWe, input bit load, input bit memWe, input bit pc, input bit ready,
                       input logic [6:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                       input bit tmo, input bit tmoCare);
    exp_t e;
    @(posedge clk);
    #1;
    reset              = rst;
    hzBus.Rs1D         = rs1d;
    hzBus.Rs2D         = rs2d;
    hzBus.Rs1E         = rs1e;
    hzBus.Rs2E         = rs2e;
    hzBus.RdE          = rde;
    hzBus.RegWriteE    = regWe;
    hzBus.ResultSrcE   = load ? LOAD_SRC : 3'b000;
    hzBus.MemWriteE    = memWe;
    hzBus.PCSrcE       = pc;
    hzBus.dmem_ready   = ready;
    e.tag     = tag;
    e.ctl     = ctl;
    e.fa      = fa;
    e.fb      = fb;
    e.tmo     = tmo;
    e.tmoCare = tmoCare;
    sbQ.push_back(e);
  endtask

  // Compare queued expectations against DUT outputs mid-cycle.
  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      exp_t e;
      e = sbQ.pop_front();
      checkVal({e.tag, "_ctl"}, 16'({hzBus.StallF, hzBus.StallD, hzBus.FlushD, hzBus.StallE,
                                     hzBus.FlushE, hzBus.StallM, hzBus.FlushW}), 16'(e.ctl));
      checkVal({e.tag, "_fwdA"}, 16'(hzBus.ForwardAE), 16'(e.fa));
      checkVal({e.tag, "_fwdB"}, 16'(hzBus.ForwardBE), 16'(e.fb));
      if (e.tmoCare)
        checkVal({e.tag, "_tmo"}, 16'(hzBus.mem_timeout), 16'(e.tmo));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecCount = 0;
    errCount = 0;
    reset = 1'b1;
    hzBus.Rs1D = 5'd0; hzBus.Rs2D = 5'd0; hzBus.Rs1E = 5'd0; hzBus.Rs2E = 5'd0;
    hzBus.RdE = 5'd0; hzBus.RegWriteE = 1'b0; hzBus.ResultSrcE = 3'b000;
    hzBus.MemWriteE = 1'b0; hzBus.PCSrcE = 1'b0; hzBus.dmem_ready = 1'b1;

    // Reset masks load-use and branch requests.
    drive("rst_hz",   1, 5, 0, 5, 0, 5, 1, 1, 0, 1, 1, C_NONE, 2'b00, 2'b00, 0, 1);
    drive("rst_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 2'b00, 2'b00, 0, 1);

    // Load-use stall, bubble, then W-path forward.
    drive("lw_use",   0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 1, C_LW,   2'b00, 2'b00, 0, 1);
    drive("lw_bub",   0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 2'b00, 2'b00, 0, 1);
    drive("lw_fwdW",  0, 0, 0, 5, 5, 0, 0, 0, 0, 0, 1, C_NONE, 2'b01, 2'b01, 0, 1);

    // Branch alone, branch with load-use, then M forward, W forward, x0 load.
    drive("br",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_BR,   2'b00, 2'b00, 0, 1);
    drive("br_lw",    0, 0, 6, 0, 0, 6, 1, 1, 0, 1, 1, C_BRLW, 2'b00, 2'b00, 0, 1);
    drive("fwdM6",    0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1, C_NONE, 2'b10, 2'b00, 0, 1);
    drive("x0_lw",    0, 0, 0, 0, 6, 0, 1, 1, 0, 0, 1, C_NONE, 2'b00, 2'b01, 0, 1);

    // RdM=RdW=7: M wins; x0 never forwards.
    drive("x0_fwd",   0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, C_NONE, 2'b00, 2'b00, 0, 1);
    drive("fwdM7",    0, 0, 0, 7, 0, 7, 1, 0, 0, 0, 1, C_NONE, 2'b10, 2'b00, 0, 1);
    drive("m_beats_w",0, 0, 0, 7, 7, 0, 0, 0, 0, 0, 1, C_NONE, 2'b10, 2'b10, 0, 1);
    drive("fwdW7",    0, 0, 0, 7, 3, 0, 0, 0, 0, 0, 1, C_NONE, 2'b01, 2'b00, 0, 1);

    // Load in M waits three cycles with a branch held in EX.
    drive("ld_issue", 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 1, C_NONE, 2'b00, 2'b00, 0, 1);
    for (int i = 0; i < 3; i++)
      drive("mwait",  0, 0, 0, 9, 0, 10, 1, 0, 0, 1, 0, C_MEM, 2'b10, 2'b00, 0, 1);
    drive("release",  0, 0, 0, 9, 0, 10, 1, 0, 0, 1, 1, C_BR,   2'b10, 2'b00, 0, 1);
    drive("post_rel", 0, 0, 0, 9, 10, 0, 0, 0, 0, 0, 1, C_NONE, 2'b01, 2'b10, 0, 1);
    drive("post_rel2",0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 1, C_NONE, 2'b00, 2'b01, 0, 1);

    // Store that waits past MAX_WAIT; timeout is sticky after ready returns.
    drive("st_issue", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_NONE, 2'b00, 2'b00, 0, 1);
    for (int i = 0; i < MAX_WAIT + 2; i++)
      drive("tmo_wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_MEM, 2'b00, 2'b00,
            (i >= MAX_WAIT + 1), ((i < MAX_WAIT - 1) || (i == MAX_WAIT + 1)));
    drive("tmo_rdy",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 2'b00, 2'b00, 1, 1);
    drive("tmo_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 2'b00, 2'b00, 1, 1);

    // Reset in the middle of a wait clears everything at once.
    drive("ld2",      0, 0, 0, 0, 0, 12, 1, 1, 0, 0, 1, C_NONE, 2'b00, 2'b00, 1, 1);
    drive("ld2_wait", 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, C_MEM, 2'b10, 2'b00, 1, 1);
    drive("ld2_wait", 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, C_MEM, 2'b10, 2'b00, 1, 1);
    drive("rst_mid",  1, 5, 0, 12, 0, 5, 1, 1, 0, 1, 0, C_NONE, 2'b00, 2'b00, 0, 1);
    drive("rst_mid2", 1, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00, 0, 1);
    drive("post_rst", 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00, 0, 1);
    drive("post_rst2",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 2'b00, 2'b00, 0, 1);

    repeat (2) @(posedge clk);
    checkVal("drain", 16'(sbQ.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
